bus_drvr_endpoint: RTL

Driver-side endpoint for the parallel bus generator/arbiter. It is the other end of the pndng/pop/D_pop and push/D_push handshake. A transmit FIFO presents pending words to the arbiter, which pops them. A receive FIFO accepts words the bus pushes, keeping only those addressed to this endpoint's ID or to the broadcast ID. One instance sits behind each driver port of the bus.

---
 rtl/bus_drvr_pkg.sv | 18 +
 rtl/bus_drvr_fifo.sv | 53 +++++
 rtl/bus_drvr_endpoint.sv | 92 +++++++++
 3 files changed

// File: rtl/bus_drvr_pkg.sv
// rtl/bus_drvr_pkg.sv - shared constants and ID extraction for the bus driver endpoint
package bus_drvr_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  // Widest word id_of() can look at; callers zero-extend narrower words.
  localparam int WORD_MAX_W = 256;

  // The destination ID is the top ID_W bits of a word_w-bit word.
  function automatic logic [ID_W-1:0] id_of(input logic [WORD_MAX_W-1:0] word,
                                            input int unsigned word_w);
    logic [WORD_MAX_W-1:0] shifted;
    shifted = word >> (word_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

endpackage

// File: rtl/bus_drvr_fifo.sv
// rtl/bus_drvr_fifo.sv - show-ahead FIFO with MSB-extended pointers
module bus_drvr_fifo
  import bus_drvr_pkg::*;
#(
  parameter int bits  = 32,
  parameter int depth = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [bits-1:0] din,
  input  logic            pop,
  output logic [bits-1:0] dout,
  output logic            empty,
  output logic            full
);

  localparam int AW = $clog2(depth);

  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [bits-1:0] mem [depth];
  logic            do_pop;
  logic            do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
  // when the same cycle frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head word is shown ahead; forced to zero while empty so stale storage never leaks.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; wrap is the natural modulo 2*depth of the extended pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the empty flag masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bus_drvr_endpoint.sv
// rtl/bus_drvr_endpoint.sv - bus driver endpoint (TX/RX FIFOs, ID filter); optional BUS_DRVR_DROP_CNT_EN
module bus_drvr_endpoint
  import bus_drvr_pkg::*;
#(
  parameter int             bits      = 32,
  parameter int             depth     = 8,
  parameter logic [ID_W-1:0] id        = 8'h00,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_push,
  input  logic [bits-1:0] tx_data,
  output logic            tx_full,
  output logic            pndng,
  output logic [bits-1:0] D_pop,
  input  logic            pop,
  input  logic            push,
  input  logic [bits-1:0] D_push,
  output logic            rx_pndng,
  output logic [bits-1:0] rx_data,
  input  logic            rx_pop,
  output logic            rx_ovf
`ifdef BUS_DRVR_DROP_CNT_EN
  ,
  output logic [15:0]     drop_cnt
`endif
);

  logic                  tx_empty;
  logic                  rx_empty;
  logic                  rx_full;
  logic                  rx_hit;
  logic                  rx_drop;
  logic [WORD_MAX_W-1:0] push_word;

  bus_drvr_fifo #(.bits(bits), .depth(depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (tx_data),
    .pop   (pop),
    .dout  (D_pop),
    .empty (tx_empty),
    .full  (tx_full)
  );

  bus_drvr_fifo #(.bits(bits), .depth(depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_hit),
    .din   (D_push),
    .pop   (rx_pop),
    .dout  (rx_data),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign pndng    = !tx_empty;
  assign rx_pndng = !rx_empty;

  // Zero-extend the bus word so the shared ID helper can handle any width.
  always_comb begin
    push_word            = '0;
    push_word[bits-1:0]  = D_push;
  end

  assign rx_hit  = push && ((id_of(push_word, bits) == id) || (id_of(push_word, bits) == broadcast));
  // Full implies non-empty, so rx_pop alone tells whether a slot frees up.
  assign rx_drop = rx_hit && rx_full && !rx_pop;

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       rx_ovf <= 1'b0;
    else if (rx_drop) rx_ovf <= 1'b1;
  end

`ifdef BUS_DRVR_DROP_CNT_EN
  logic        tx_drop;
  logic [16:0] drop_sum;

  assign tx_drop  = tx_push && tx_full && !pop;
  assign drop_sum = {1'b0, drop_cnt} + 17'(tx_drop) + 17'(rx_drop);

  // Saturating count of dropped words; TX and RX drops may both land in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  drop_cnt <= '0;
    else         drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`endif

endmodule
